// File: rtl/handshake_pkg.sv
// Shared types and constants for the processor/peripheral send/ack handshake.
package handshake_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam logic [1:0] SEND_IDLE = 2'b00;
  localparam logic [1:0] SEND_REQ  = 2'b01;
  localparam logic [1:0] ACK_OFF   = 2'b00;
  localparam logic [1:0] ACK_ON    = 2'b01;

  // Default data width, matching the processor dado bus.
  localparam int DW_DEFAULT = 16;

endpackage

// File: rtl/periph_fifo.sv
// First-word-fall-through circular FIFO holding words accepted from the processor.
module periph_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Storage write; contents are never reset, the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head word is read asynchronously so it is visible right after the writing edge.
  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW + 1)'(DEPTH));

endmodule

// File: rtl/fsm_periferico.sv
// Peripheral-side 4-phase handshake receiver: buffers each request word in a FIFO,
// stalls ack while the FIFO is full, and counts accepted words and illegal requests.
module fsm_periferico
  import handshake_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    send,
  input  logic [DW-1:0] dado,
  output logic [1:0]    ack,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [15:0]   rx_count,
  output logic [7:0]    err_count,
  output logic          full
);

  state_t state;
  state_t state_next;
  logic   push;
  logic   pop;
  logic   empty;
  logic   illegal;

  assign illegal   = send[1];
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign ack       = (state == ACK) ? ACK_ON : ACK_OFF;

  periph_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (dado),
    .pop   (pop),
    .dout  (out_data),
    .empty (empty),
    .full  (full)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and push decision; a request seen while full is simply retried next cycle.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (send == SEND_REQ && !full) begin
          push       = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        if (send == SEND_IDLE) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accepted-word counter (wraps) and illegal-request counter (saturates).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_count  <= '0;
      err_count <= '0;
    end else begin
      if (push) begin
        rx_count <= rx_count + 16'd1;
      end
      if (illegal && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fsm_periferico.sv
// Directed, table-driven testbench for fsm_periferico.
module tb_fsm_periferico;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  send = 2'b00;
  logic [15:0] dado = '0;
  logic [1:0]  ack;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic [15:0] rx_count;
  logic [7:0]  err_count;
  logic        full;

  int checks = 0;
  int errors = 0;

  fsm_periferico #(.DEPTH(4), .DW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .dado      (dado),
    .ack       (ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .rx_count  (rx_count),
    .err_count (err_count),
    .full      (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  send;
    logic [15:0] dado;
    logic        rdy;
    logic [1:0]  ack;
    logic        valid;
    logic [15:0] data;
    logic [15:0] rx;
    logic [7:0]  err;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; afterwards outputs reflect the edge that sampled the current inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    send = 2'b00;
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Full 2-cycle handshake: request up for one edge, then down for one edge.
  task automatic handshake(input logic [15:0] v);
    send = 2'b01;
    dado = v;
    step();
    check("hs_ack_up", 32'(ack), 32'h1);
    $display("handshake dado=%04h ack=%0d rx=%0d", v, ack, rx_count);
    send = 2'b00;
    step();
    check("hs_ack_down", 32'(ack), 32'h0);
  endtask

  initial begin
    vecs[0]  = '{2'b01, 16'h00A5, 1'b0, 2'b01, 1'b1, 16'h00A5, 16'd1, 8'd0};
    vecs[1]  = '{2'b01, 16'h00A5, 1'b0, 2'b01, 1'b1, 16'h00A5, 16'd1, 8'd0};
    vecs[2]  = '{2'b01, 16'h00A5, 1'b0, 2'b01, 1'b1, 16'h00A5, 16'd1, 8'd0};
    vecs[3]  = '{2'b00, 16'h0000, 1'b0, 2'b00, 1'b1, 16'h00A5, 16'd1, 8'd0};
    vecs[4]  = '{2'b00, 16'h0000, 1'b1, 2'b00, 1'b0, 16'h0000, 16'd1, 8'd0};
    vecs[5]  = '{2'b11, 16'h0000, 1'b0, 2'b00, 1'b0, 16'h0000, 16'd1, 8'd1};
    vecs[6]  = '{2'b10, 16'h0000, 1'b0, 2'b00, 1'b0, 16'h0000, 16'd1, 8'd2};
    vecs[7]  = '{2'b01, 16'h1234, 1'b0, 2'b01, 1'b1, 16'h1234, 16'd2, 8'd2};
    vecs[8]  = '{2'b11, 16'h1234, 1'b0, 2'b01, 1'b1, 16'h1234, 16'd2, 8'd3};
    vecs[9]  = '{2'b00, 16'h0000, 1'b0, 2'b00, 1'b1, 16'h1234, 16'd2, 8'd3};
    vecs[10] = '{2'b00, 16'h0000, 1'b1, 2'b00, 1'b0, 16'h0000, 16'd2, 8'd3};

    // Reset state
    do_reset();
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_full", 32'(full), 32'h0);
    check("rst_rx", 32'(rx_count), 32'h0);
    check("rst_err", 32'(err_count), 32'h0);

    // Table: single transfer, pop, illegal values in IDLE and ACK
    for (int i = 0; i < 11; i++) begin
      send = vecs[i].send;
      dado = vecs[i].dado;
      out_ready = vecs[i].rdy;
      step();
      $display("vec %0d send=%b dado=%04h rdy=%b -> ack=%b valid=%b data=%04h rx=%0d err=%0d",
               i, send, dado, out_ready, ack, out_valid, out_data, rx_count, err_count);
      check($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].ack));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].data));
      check($sformatf("vec%0d_rx", i), 32'(rx_count), 32'(vecs[i].rx));
      check($sformatf("vec%0d_err", i), 32'(err_count), 32'(vecs[i].err));
    end

    // Fill and stall
    do_reset();
    for (int v = 1; v <= 4; v++) handshake(16'(v));
    check("fill_full", 32'(full), 32'h1);
    check("fill_rx", 32'(rx_count), 32'd4);
    send = 2'b01;
    dado = 16'd5;
    for (int c = 0; c < 10; c++) begin
      step();
      check("stall_ack", 32'(ack), 32'h0);
      check("stall_rx", 32'(rx_count), 32'd4);
      check("stall_head", 32'(out_data), 32'd1);
    end
    $display("stall 10 cycles ack=%b full=%b", ack, full);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pop_ack_still_low", 32'(ack), 32'h0);
    check("pop_full_clear", 32'(full), 32'h0);
    check("pop_head", 32'(out_data), 32'd2);
    step();
    check("unstall_ack", 32'(ack), 32'h1);
    check("unstall_full", 32'(full), 32'h1);
    check("unstall_rx", 32'(rx_count), 32'd5);
    send = 2'b00;
    step();
    for (int v = 2; v <= 5; v++) begin
      check("drain_valid", 32'(out_valid), 32'h1);
      check("drain_data", 32'(out_data), 32'(v));
      $display("drain word=%0d", out_data);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    check("drain_empty", 32'(out_valid), 32'h0);

    // Pointer wrap with consumer always ready
    do_reset();
    out_ready = 1'b1;
    for (int v = 10; v <= 19; v++) begin
      send = 2'b01;
      dado = 16'(v);
      step();
      check("wrap_ack", 32'(ack), 32'h1);
      check("wrap_valid", 32'(out_valid), 32'h1);
      check("wrap_data", 32'(out_data), 32'(v));
      check("wrap_nofull", 32'(full), 32'h0);
      $display("wrap push %0d head=%0d", v, out_data);
      send = 2'b00;
      step();
      check("wrap_popped", 32'(out_valid), 32'h0);
    end
    check("wrap_rx", 32'(rx_count), 32'd10);

    // Illegal request saturation
    out_ready = 1'b0;
    send = 2'b11;
    for (int c = 0; c < 300; c++) step();
    send = 2'b00;
    $display("illegal x300 err=%0d ack=%b", err_count, ack);
    check("illegal_err_sat", 32'(err_count), 32'd255);
    check("illegal_ack", 32'(ack), 32'h0);
    check("illegal_nopush", 32'(out_valid), 32'h0);
    check("illegal_rx", 32'(rx_count), 32'd10);

    // Concurrent push and pop
    handshake(16'h0AAA);
    out_ready = 1'b1;
    send = 2'b01;
    dado = 16'h0BBB;
    step();
    check("conc_valid", 32'(out_valid), 32'h1);
    check("conc_data", 32'(out_data), 32'h0BBB);
    check("conc_rx", 32'(rx_count), 32'd12);
    $display("concurrent push/pop head=%04h", out_data);
    send = 2'b00;
    step();
    check("conc_drained", 32'(out_valid), 32'h0);
    out_ready = 1'b0;

    // Reset mid-handshake
    do_reset();
    handshake(16'h0C01);
    send = 2'b01;
    dado = 16'h0C02;
    step();
    send = 2'b11;
    step();
    check("pre_rst_ack", 32'(ack), 32'h1);
    check("pre_rst_err", 32'(err_count), 32'd1);
    send = 2'b01;
    rst = 1'b1;
    #1;
    check("async_ack", 32'(ack), 32'h0);
    check("async_valid", 32'(out_valid), 32'h0);
    check("async_rx", 32'(rx_count), 32'h0);
    check("async_err", 32'(err_count), 32'h0);
    $display("async reset ack=%b valid=%b rx=%0d err=%0d", ack, out_valid, rx_count, err_count);
    step();
    rst = 1'b0;
    step();
    check("rerequest_ack", 32'(ack), 32'h1);
    check("rerequest_rx", 32'(rx_count), 32'd1);
    check("rerequest_data", 32'(out_data), 32'h0C02);
    send = 2'b00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
